// File: rtl/mips_decode_seq.sv
// Registered MIPS decoder with valid/ready handshakes on both sides; sequences addm as a
// load micro-op, MEM_WAIT bubble cycles, then an add micro-op.
module mips_decode_seq #(
  parameter int unsigned ADDM_EN       = 1,
  parameter int unsigned MEM_WAIT      = 0,
  parameter int unsigned STICKY_EXCEPT = 1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_instr,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic        i_out_ready,
  output logic        o_out_valid,
  output logic [2:0]  o_alu_op,
  output logic [1:0]  o_alu_src2,
  output logic        o_writeenable,
  output logic        o_rd_src,
  output logic        o_except,
  output logic        o_mem_read,
  output logic        o_word_we,
  output logic        o_byte_we,
  output logic        o_byte_load,
  output logic        o_slt,
  output logic        o_lui,
  output logic [1:0]  o_ctl_kind,
  output logic        o_is_jump,
  output logic        o_addm,
  output logic        o_addm_phase,
  output logic        o_uop_last,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [15:0] o_imm16,
  output logic        o_halted
);

  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] alu_src2;
    logic       writeenable;
    logic       rd_src;
    logic       except;
    logic       mem_read;
    logic       word_we;
    logic       byte_we;
    logic       byte_load;
    logic       slt;
    logic       lui;
    logic [1:0] ctl_kind;
    logic       is_jump;
    logic       addm;
    logic       addm_phase;
    logic       uop_last;
  } ctl_t;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAddm2} state_e;

  localparam logic [2:0] AluAddu = 3'd0;
  localparam logic [2:0] AluAdd  = 3'd2;
  localparam logic [2:0] AluSub  = 3'd3;
  localparam logic [2:0] AluAnd  = 3'd4;
  localparam logic [2:0] AluOr   = 3'd5;
  localparam logic [2:0] AluNor  = 3'd6;
  localparam logic [2:0] AluXor  = 3'd7;

  localparam logic [2:0] WaitLoad = (MEM_WAIT == 0) ? 3'd0 : 3'(MEM_WAIT - 1);
  localparam bit         Sticky   = (STICKY_EXCEPT != 0);
  localparam ctl_t       AddUop   = '{alu_op: AluAdd, writeenable: 1'b1, addm: 1'b1,
                                      addm_phase: 1'b1, uop_last: 1'b1, default: '0};

  state_e      r_state, w_state_next;
  ctl_t        r_ctl, w_ctl_next, w_dec;
  logic [25:0] r_fields, w_fields_next;
  logic [2:0]  r_cnt, w_cnt_next;
  logic        r_halted, w_halted_next;
  logic        w_illegal, w_accept, w_xfer, w_sticky_hit;
  logic [5:0]  w_op, w_fn;

  assign w_op = i_instr[31:26];
  assign w_fn = i_instr[5:0];

  always_comb begin
    w_dec          = '0;
    w_dec.uop_last = 1'b1;
    w_illegal      = 1'b0;
    case (w_op)
      6'h00: begin
        case (w_fn)
          6'h08: w_dec.ctl_kind = 2'd3;
          6'h20: begin w_dec.alu_op = AluAdd;  w_dec.writeenable = 1'b1; end
          6'h21: begin w_dec.alu_op = AluAddu; w_dec.writeenable = 1'b1; end
          6'h22: begin w_dec.alu_op = AluSub;  w_dec.writeenable = 1'b1; end
          6'h24: begin w_dec.alu_op = AluAnd;  w_dec.writeenable = 1'b1; end
          6'h25: begin w_dec.alu_op = AluOr;   w_dec.writeenable = 1'b1; end
          6'h26: begin w_dec.alu_op = AluXor;  w_dec.writeenable = 1'b1; end
          6'h27: begin w_dec.alu_op = AluNor;  w_dec.writeenable = 1'b1; end
          6'h2a: begin
            w_dec.alu_op      = AluSub;
            w_dec.slt         = 1'b1;
            w_dec.writeenable = 1'b1;
          end
          6'h2c: begin
            if (ADDM_EN != 0) begin
              w_dec.alu_op   = AluAdd;
              w_dec.mem_read = 1'b1;
              w_dec.addm     = 1'b1;
              w_dec.uop_last = 1'b0;
            end else begin
              w_illegal = 1'b1;
            end
          end
          default: w_illegal = 1'b1;
        endcase
      end
      6'h02: begin w_dec.ctl_kind = 2'd2; w_dec.is_jump = 1'b1; end
      6'h04: begin w_dec.ctl_kind = 2'd1; w_dec.alu_op = AluSub; end
      6'h05: begin w_dec.ctl_kind = 2'd2; w_dec.alu_op = AluSub; end
      6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e: begin
        w_dec.writeenable = 1'b1;
        w_dec.rd_src      = 1'b1;
        w_dec.alu_src2    = (w_op[3:2] == 2'b11) ? 2'd2 : 2'd1;
        w_dec.alu_op      = (w_op == 6'h08) ? AluAdd  : (w_op == 6'h09) ? AluAddu :
                            (w_op == 6'h0c) ? AluAnd  : (w_op == 6'h0d) ? AluOr : AluXor;
      end
      6'h0f: begin w_dec.lui = 1'b1; w_dec.writeenable = 1'b1; w_dec.rd_src = 1'b1; end
      6'h23, 6'h24: begin
        w_dec.alu_op      = AluAdd;
        w_dec.alu_src2    = 2'd1;
        w_dec.mem_read    = 1'b1;
        w_dec.writeenable = 1'b1;
        w_dec.rd_src      = 1'b1;
        w_dec.byte_load   = (w_op == 6'h24);
      end
      6'h28, 6'h2b: begin
        w_dec.alu_op   = AluAdd;
        w_dec.alu_src2 = 2'd1;
        w_dec.byte_we  = (w_op == 6'h28);
        w_dec.word_we  = (w_op == 6'h2b);
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_dec          = '0;
      w_dec.except   = 1'b1;
      w_dec.uop_last = 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= StIdle;
      r_ctl    <= '0;
      r_fields <= '0;
      r_cnt    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_ctl    <= w_ctl_next;
      r_fields <= w_fields_next;
      r_cnt    <= w_cnt_next;
      r_halted <= w_halted_next;
    end
  end

  // A transferring sticky except must not let a new instruction slip in the same cycle.
  assign w_sticky_hit = Sticky & r_ctl.except;
  assign w_accept     = i_in_valid & o_in_ready;
  assign w_xfer       = o_out_valid & i_out_ready;

  always_comb begin
    w_state_next  = r_state;
    w_ctl_next    = r_ctl;
    w_fields_next = r_fields;
    w_cnt_next    = r_cnt;
    w_halted_next = r_halted;
    case (r_state)
      StIdle: ;
      StIssue, StAddm2: begin
        if (w_xfer) begin
          if (r_ctl.uop_last) begin
            w_state_next = StIdle;
            if (w_sticky_hit) w_halted_next = 1'b1;
          end else if (MEM_WAIT == 0) begin
            w_state_next = StAddm2;
            w_ctl_next   = AddUop;
          end else begin
            w_state_next = StWait;
            w_cnt_next   = WaitLoad;
          end
        end
      end
      StWait: begin
        if (r_cnt == 3'd0) begin
          w_state_next = StAddm2;
          w_ctl_next   = AddUop;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      default: w_state_next = StIdle;
    endcase
    if (w_accept) begin
      w_state_next  = StIssue;
      w_ctl_next    = w_dec;
      w_fields_next = i_instr[25:0];
    end
  end

  always_comb begin
    o_out_valid   = (r_state == StIssue) | (r_state == StAddm2);
    o_in_ready    = ~r_halted & ((r_state == StIdle) |
                    (o_out_valid & i_out_ready & r_ctl.uop_last & ~w_sticky_hit));
    o_alu_op      = r_ctl.alu_op;
    o_alu_src2    = r_ctl.alu_src2;
    o_writeenable = r_ctl.writeenable;
    o_rd_src      = r_ctl.rd_src;
    o_except      = r_ctl.except;
    o_mem_read    = r_ctl.mem_read;
    o_word_we     = r_ctl.word_we;
    o_byte_we     = r_ctl.byte_we;
    o_byte_load   = r_ctl.byte_load;
    o_slt         = r_ctl.slt;
    o_lui         = r_ctl.lui;
    o_ctl_kind    = r_ctl.ctl_kind;
    o_is_jump     = r_ctl.is_jump;
    o_addm        = r_ctl.addm;
    o_addm_phase  = r_ctl.addm_phase;
    o_uop_last    = r_ctl.uop_last;
    o_rs          = r_fields[25:21];
    o_rt          = r_fields[20:16];
    o_rd          = r_fields[15:11];
    o_imm16       = r_fields[15:0];
    o_halted      = r_halted;
  end

endmodule

// File: doc/mips_decode_seq.md
Name: mips_decode_seq

Overview:
Registered, handshaked successor to the combinational MIPS decoder. It accepts one 32-bit instruction per cycle, decodes it into the same control bundle plus register fields, and sequences multi-micro-op instructions: addm issues as a load micro-op, an optional wait, then an add micro-op. The block sits between the fetch buffer and the execute stage. Branch resolution is not done here; zero stays in execute.

Parameters:
ADDM_EN, 1, 1 = addm decoded as a legal two-uop instruction; 0 = addm raises except.
MEM_WAIT, 0, bubble cycles inserted between the addm load uop and the addm add uop (0..7).
STICKY_EXCEPT, 1, 1 = after an except uop is accepted, block halts until reset; 0 = continues.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
instr  in  32  instruction word
in_valid  in  1  instr valid
in_ready  out  1  block accepts instr this cycle
out_ready  in  1  execute accepts current uop
out_valid  out  1  uop outputs valid
alu_op  out  3  ADDU=0, ADD=2, SUB=3, AND=4, OR=5, NOR=6, XOR=7
alu_src2  out  2  0 = reg, 1 = sign-ext imm, 2 = zero-ext imm
writeenable, rd_src, except, mem_read, word_we, byte_we, byte_load, slt, lui  out  1 each  as the existing decoder
ctl_kind  out  2  0 = fallthrough, 1 = beq, 2 = bne/j select via is_jump, 3 = jr
is_jump  out  1  with ctl_kind=2: 1 = j, 0 = bne
addm  out  1  uop belongs to addm
addm_phase  out  1  0 = load uop, 1 = add uop
uop_last  out  1  final uop of the instruction
rs, rt, rd  out  5 each  register fields
imm16  out  16  instr[15:0]
halted  out  1  sticky-exception halt

Behaviour:
- Encodings. Opcode: 00 = other, 02 = J, 04 = BEQ, 05 = BNE, 08 = ADDI, 09 = ADDIU, 0C = ANDI, 0D = ORI, 0E = XORI, 0F = LUI, 23 = LW, 24 = LBU, 28 = SB, 2B = SW. Funct: 08 = JR, 20–27 = ADD..NOR, 2A = SLT, 2C = ADDM.
- Decode table. Single-uop fields are identical to the combinational decoder for all legal instructions. SUBU (funct 23) is illegal.
- Except uop. Any other opcode/funct combination decodes to a single uop with except=1 and writeenable, mem_read, word_we and byte_we all 0.
- Reset values. out_valid=0, halted=0, all control outputs 0, fields 0, state IDLE. in_ready is 1 once reset deasserts.
- State IDLE. out_valid=0.
- State ISSUE. out_valid=1; holds the uop.
- State WAIT. out_valid=0; counter runs MEM_WAIT cycles.
- State ADDM2. out_valid=1; holds the add uop.
- in_ready = ~halted & (state==IDLE | (state∈{ISSUE, ADDM2} & out_ready & uop_last)). This gives a sustained throughput of 1 instr/cycle for single-uop instructions.
- Accept (in_valid & in_ready):
  - Registers all outputs on the next edge and moves to ISSUE.
  - For addm, the load uop is: mem_read=1, alu_op=ADD, alu_src2=0, writeenable=0, addm=1, addm_phase=0, uop_last=0.
- Transfer (out_valid & out_ready):
  - uop_last=1 → next accepted instr, or IDLE if none.
  - addm load uop with MEM_WAIT=0 → ADDM2.
  - addm load uop with MEM_WAIT>0 → WAIT, counter loaded with MEM_WAIT-1. WAIT decrements each cycle and goes to ADDM2 when it reaches 0.
- ADDM2 uop: alu_op=ADD, alu_src2=0, writeenable=1, rd_src=0, mem_read=0, addm=1, addm_phase=1, uop_last=1.
- Stall. While out_valid & ~out_ready, every output is held stable.
- Sticky exception. If STICKY_EXCEPT=1 and an except uop transfers, halted=1 on the next edge, in_ready=0, and the block returns to IDLE. Only reset clears halted.
- Reset mid-operation. Asynchronous return to reset values; any in-flight addm is discarded.
- Simultaneous events. Transfer of a last uop and accept of a new instr in the same cycle means the new uop appears next cycle with no bubble.

Test Plan:
- Reset, then addu $3,$1,$2 (0x00221821) with out_ready=1 → 1 cycle later: out_valid=1, alu_op=0, writeenable=1, rd_src=0, rd=3, uop_last=1.
- Back-to-back ori 0x34220005 then lw 0x8C230004 with out_ready=1 → consecutive uops, no bubble; ori alu_src2=2, lw alu_src2=1, mem_read=1, rd_src=1.
- addm 0x0022182C with MEM_WAIT=2 → load uop (addm_phase=0, mem_read=1), then 2 cycles out_valid=0 and in_ready=0, then add uop (addm_phase=1, writeenable=1, uop_last=1).
- beq 0x10220003 with out_ready=0 for 3 cycles → ctl_kind=1, alu_op=3, all outputs stable and in_ready=0 until out_ready=1.
- subu funct 23 with STICKY_EXCEPT=1 → except=1, writeenable=0; after transfer halted=1, in_ready=0; a later valid instr is never accepted until reset.
- Reset asserted during WAIT of addm → out_valid=0 and halted=0 immediately; next instr decodes normally.
